segre_mem_arbiter: RTL and testbench
====================================

# segre_mem_arbiter

Shares the single main-memory line port between the instruction-cache miss path and the data-cache miss/writeback path. Each cache holds a level request until it receives a one-cycle ready pulse. The arbiter grants requests round-robin, drives one memory transaction at a time with a stable request/acknowledge handshake, and routes the returned line to the winner. A watchdog flags memory transactions that never acknowledge.

## Interface
Parameters:
- ADDR_SIZE, 32, address width
- LINE_BYTES, 16, cache line size in bytes (equals CACHE_LINE_SIZE_BYTES)
- TIMEOUT, 64, maximum cycles to wait for mem_ack_i; must be ≥ 2

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ic_rd_i  in  1  icache line-fill request (level)
- ic_addr_i  in  ADDR_SIZE  icache fill address
- ic_ready_o  out  1  icache transaction-done pulse
- dc_rd_i  in  1  dcache line-fill request (level)
- dc_wr_i  in  1  dcache writeback request (level)
- dc_addr_i  in  ADDR_SIZE  dcache address
- dc_line_i  in  LINE_BYTES×8  dcache writeback data
- dc_ready_o  out  1  dcache transaction-done pulse
- line_o  out  LINE_BYTES×8  returned fill line; valid with a ready pulse
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_SIZE  memory address, line-aligned
- mem_wdata_o  out  LINE_BYTES×8  write data
- mem_ack_i  in  1  memory acknowledge; read data valid in the same cycle
- mem_rdata_i  in  LINE_BYTES×8  read line
- timeout_o  out  1  sticky watchdog error flag

## Operation
- FSM states: IDLE, BUSY_IC, BUSY_DC, RESP.
- IDLE with pending requests:
  - Grant the icache if only ic_rd_i is high.
  - Grant the dcache if only dc_rd_i or dc_wr_i is high.
  - If both caches request, grant the side not recorded in last_grant.
  - last_grant resets to DC, so the icache wins the first tie.
- On grant, latch the following and move to BUSY_IC or BUSY_DC:
  - the address, with its low log2(LINE_BYTES) bits cleared;
  - the operation;
  - for a dcache write, dc_line_i.
- dcache with dc_wr_i and dc_rd_i both high: the write is served first as its own transaction. The read re-arbitrates afterwards.
- BUSY_x behaviour:
  - mem_req_o = 1; mem_addr_o, mem_we_o and mem_wdata_o are held stable.
  - On mem_ack_i: capture mem_rdata_i into line_o (reads only; writes leave line_o unchanged), update last_grant, move to RESP.
  - The watchdog counter increments every BUSY cycle. When it reaches TIMEOUT-1 without ack: set timeout_o, drop the request, go to IDLE. No ready pulse is issued; the still-asserted request re-arbitrates.
- RESP: pulse exactly one of ic_ready_o / dc_ready_o, then go to IDLE.
  - No grant happens in RESP.
  - The requester must deassert or change its request in the cycle it sees ready.
- mem_ack_i outside BUSY is ignored.
- timeout_o is cleared only by reset.

## Timing
- Reset values (asynchronous): state IDLE, last_grant DC, watchdog count 0. All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, line_o, both ready pulses, timeout_o.
- Request seen in IDLE at cycle t → mem_req_o = 1 at t+1.
- mem_ack_i at cycle a → mem_req_o = 0 and ready = 1 at a+1, with line_o valid the same cycle → IDLE at a+2 → earliest next mem_req_o at a+3.
- Minimum transaction: ack in the first BUSY cycle gives 3 cycles from request to ready.
- Reset mid-transaction aborts immediately. Memory must tolerate a dropped mem_req_o.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- segre_pkg gets:
  - arb_state_e {IDLE, BUSY_IC, BUSY_DC, RESP};
  - requester_e {REQ_IC, REQ_DC};
  - reuse of CACHE_LINE_SIZE_BYTES and ADDR_SIZE.
- One natural sub-module: segre_arb_watchdog. It holds the counter plus terminal-count compare, with ports clk_i, rst_i, clear, enable, expired.
- Arbiter FSM and datapath registers stay in the top module.

## Test plan
- Reset, then ic_rd_i = 1 with ic_addr_i = 0x104 and ack 2 cycles after request:
  - mem_addr_o = 0x100 and mem_we_o = 0;
  - ic_ready_o pulses once with line_o = mem_rdata_i;
  - dc_ready_o stays 0.
- ic_rd_i and dc_rd_i asserted together and held; each cache drops its request on ready:
  - first the IC is granted, then DC;
  - a second simultaneous pair is granted IC then DC again (alternation holds).
- dc_wr_i = dc_rd_i = 1 with dc_line_i = 0xA5…A5:
  - first transaction has mem_we_o = 1 and mem_wdata_o = 0xA5…A5, and dc_ready_o pulses;
  - with dc_wr_i dropped, the next transaction is a read.
- Grant the icache, then hold mem_ack_i = 0 for TIMEOUT cycles:
  - timeout_o rises and mem_req_o falls;
  - no ready pulse occurs;
  - the request re-issues; a later ack completes it normally with timeout_o still 1.
- Assert rst_i while in BUSY_DC: all outputs are 0 asynchronously. After release, a pending ic_rd_i wins first (last_grant = DC).
- Pulse mem_ack_i while in IDLE: no state change and no ready pulse.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types and sizing constants for the segre memory subsystem.
//   arb_state_e  : memory arbiter FSM states
//   requester_e  : identifies which cache owns a memory transaction
package segre_pkg;

  localparam int unsigned ADDR_SIZE             = 32;
  localparam int unsigned CACHE_LINE_SIZE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IC,
    BUSY_DC,
    RESP
  } arb_state_e;

  typedef enum logic {
    REQ_IC,
    REQ_DC
  } requester_e;

endpackage

// File: rtl/segre_arb_watchdog.sv
// Watchdog for an outstanding memory transaction.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear        : hold the count at zero (asserted whenever no transaction is open)
//   enable       : count one cycle of an open transaction
//   expired      : high in the cycle the count equals TIMEOUT-1 (registered)
module segre_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count_q;

  // expired is raised one cycle early so it is a flop output aligned with count == TIMEOUT-1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
      expired <= (count_q == CNT_W'(TIMEOUT - 2));
    end
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Round-robin arbiter sharing the main-memory line port between the icache
// fill path and the dcache fill/writeback path.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   ic_rd_i, ic_addr_i      : icache fill request (level) and address
//   ic_ready_o              : icache one-cycle done pulse
//   dc_rd_i, dc_wr_i        : dcache fill / writeback requests (level)
//   dc_addr_i, dc_line_i    : dcache address and writeback line
//   dc_ready_o              : dcache one-cycle done pulse
//   line_o                  : returned fill line, valid with a ready pulse
//   mem_req_o .. mem_wdata_o: memory request, held stable until ack
//   mem_ack_i, mem_rdata_i  : memory acknowledge and read line (same cycle)
//   timeout_o               : sticky flag, a transaction never acknowledged
module segre_mem_arbiter #(
  parameter int unsigned ADDR_SIZE  = segre_pkg::ADDR_SIZE,
  parameter int unsigned LINE_BYTES = segre_pkg::CACHE_LINE_SIZE_BYTES,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ic_rd_i,
  input  logic [ADDR_SIZE-1:0]    ic_addr_i,
  output logic                    ic_ready_o,
  input  logic                    dc_rd_i,
  input  logic                    dc_wr_i,
  input  logic [ADDR_SIZE-1:0]    dc_addr_i,
  input  logic [LINE_BYTES*8-1:0] dc_line_i,
  output logic                    dc_ready_o,
  output logic [LINE_BYTES*8-1:0] line_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_SIZE-1:0]    mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [LINE_BYTES*8-1:0] mem_rdata_i,
  output logic                    timeout_o
);

  import segre_pkg::*;

  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'(LINE_BYTES - 1);

  arb_state_e            state_q, state_d;
  requester_e            last_grant_q, last_grant_d;
  logic                  mem_req_d, mem_we_d, ic_ready_d, dc_ready_d, timeout_d;
  logic [ADDR_SIZE-1:0]  mem_addr_d;
  logic [LINE_W-1:0]     mem_wdata_d, line_d;
  logic                  ic_pend, dc_pend, grant_dc, busy, wd_expired;

  assign ic_pend  = ic_rd_i;
  assign dc_pend  = dc_rd_i | dc_wr_i;
  // On a tie the side that did not complete last wins
  assign grant_dc = dc_pend & (~ic_pend | (last_grant_q == REQ_IC));
  assign busy     = (state_q == BUSY_IC) | (state_q == BUSY_DC);

  segre_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (~busy),
    .enable  (busy),
    .expired (wd_expired)
  );

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DC;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      line_o       <= '0;
      ic_ready_o   <= 1'b0;
      dc_ready_o   <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_o    <= mem_req_d;
      mem_we_o     <= mem_we_d;
      mem_addr_o   <= mem_addr_d;
      mem_wdata_o  <= mem_wdata_d;
      line_o       <= line_d;
      ic_ready_o   <= ic_ready_d;
      dc_ready_o   <= dc_ready_d;
      timeout_o    <= timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_o;
    mem_we_d     = mem_we_o;
    mem_addr_d   = mem_addr_o;
    mem_wdata_d  = mem_wdata_o;
    line_d       = line_o;
    ic_ready_d   = 1'b0;
    dc_ready_d   = 1'b0;
    timeout_d    = timeout_o;

    case (state_q)
      IDLE: begin
        if (ic_pend | dc_pend) begin
          mem_req_d = 1'b1;
          if (grant_dc) begin
            // A pending writeback goes first; the fill re-arbitrates afterwards
            state_d    = BUSY_DC;
            mem_we_d   = dc_wr_i;
            mem_addr_d = dc_addr_i & LINE_MASK;
            if (dc_wr_i) begin
              mem_wdata_d = dc_line_i;
            end
          end else begin
            state_d    = BUSY_IC;
            mem_we_d   = 1'b0;
            mem_addr_d = ic_addr_i & LINE_MASK;
          end
        end
      end

      BUSY_IC, BUSY_DC: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (!mem_we_o) begin
            line_d = mem_rdata_i;
          end
          if (state_q == BUSY_IC) begin
            ic_ready_d   = 1'b1;
            last_grant_d = REQ_IC;
          end else begin
            dc_ready_d   = 1'b1;
            last_grant_d = REQ_DC;
          end
        end else if (wd_expired) begin
          // Abandon silently; the requester still holds its level request
          timeout_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
module tb_segre_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LB = 16;
  localparam int unsigned LW = LB * 8;
  localparam int unsigned TO = 8;

  logic          clk_i;
  logic          rst_i;
  logic          ic_rd_i;
  logic [AW-1:0] ic_addr_i;
  logic          ic_ready_o;
  logic          dc_rd_i;
  logic          dc_wr_i;
  logic [AW-1:0] dc_addr_i;
  logic [LW-1:0] dc_line_i;
  logic          dc_ready_o;
  logic [LW-1:0] line_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [LW-1:0] mem_rdata_i;
  logic          timeout_o;

  segre_mem_arbiter #(
    .ADDR_SIZE  (AW),
    .LINE_BYTES (LB),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ic_rd_i     (ic_rd_i),
    .ic_addr_i   (ic_addr_i),
    .ic_ready_o  (ic_ready_o),
    .dc_rd_i     (dc_rd_i),
    .dc_wr_i     (dc_wr_i),
    .dc_addr_i   (dc_addr_i),
    .dc_line_i   (dc_line_i),
    .dc_ready_o  (dc_ready_o),
    .line_o      (line_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .timeout_o   (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          is_dc;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  typedef struct {
    bit            ok;
    int            wait_cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    bit            stable;
    bit            early_rdy;
    logic          ic_rdy;
    logic          dc_rdy;
    logic [LW-1:0] line;
    logic          req_after;
  } obs_t;

  exp_t          exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  bit            mdl_last_dc;
  logic [LW-1:0] mdl_line;

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory responder: waits for a request, holds ack low for delay cycles,
  // then acks and records what the arbiter presented and how it responded.
  task automatic mem_txn(input int delay, input logic [LW-1:0] rdata, output obs_t o);
    o.ok = 0; o.wait_cyc = 0; o.stable = 1; o.early_rdy = 0;
    o.we = 0; o.addr = '0; o.wdata = '0; o.ic_rdy = 0; o.dc_rdy = 0; o.line = '0; o.req_after = 0;
    while (mem_req_o !== 1'b1 && o.wait_cyc < 50) begin
      @(negedge clk_i);
      o.wait_cyc++;
    end
    if (mem_req_o !== 1'b1) return;
    o.ok = 1; o.we = mem_we_o; o.addr = mem_addr_o; o.wdata = mem_wdata_o;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      if (mem_req_o !== 1'b1 || mem_we_o !== o.we || mem_addr_o !== o.addr || mem_wdata_o !== o.wdata)
        o.stable = 0;
      if (ic_ready_o !== 1'b0 || dc_ready_o !== 1'b0) o.early_rdy = 1;
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = rdata;
    @(negedge clk_i);
    mem_ack_i   = 1'b0;
    mem_rdata_i = rnd_line();
    o.ic_rdy = ic_ready_o; o.dc_rdy = dc_ready_o; o.line = line_o; o.req_after = mem_req_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ic_rd_i = 0; ic_addr_i = '0; dc_rd_i = 0; dc_wr_i = 0; dc_addr_i = '0;
    dc_line_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({mem_req_o, mem_we_o, ic_ready_o, dc_ready_o, timeout_o} !== 5'b0)
      begin miscompares++; $display("FAIL reset_ctl: got %b expected 00000", {mem_req_o, mem_we_o, ic_ready_o, dc_ready_o, timeout_o}); end
    vectors++;
    if (mem_addr_o !== '0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
    vectors++;
    if (mem_wdata_o !== '0 || line_o !== '0)
      begin miscompares++; $display("FAIL reset_data: got wdata %h line %h expected 0", mem_wdata_o, line_o); end
    rst_i = 1'b0;
    mdl_last_dc = 1'b1;
    mdl_line    = '0;
    @(negedge clk_i);
  endtask

  task automatic test_arbitration();
    exp_t e; obs_t o; logic [LW-1:0] rd;
    for (int r = 0; r < 2; r++) begin
      bit first_dc;
      @(negedge clk_i);
      first_dc = !mdl_last_dc;
      exp_q.push_back('{is_dc: first_dc, we: 1'b0, addr: (first_dc ? 32'h3000 : 32'h2000) + AW'(r * 'h40), wdata: '0, rdata: rnd_line()});
      exp_q.push_back('{is_dc: !first_dc, we: 1'b0, addr: (first_dc ? 32'h2000 : 32'h3000) + AW'(r * 'h40), wdata: '0, rdata: rnd_line()});
      ic_addr_i = 32'h2008 + AW'(r * 'h40); dc_addr_i = 32'h300F + AW'(r * 'h40);
      ic_rd_i = 1'b1; dc_rd_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
        e  = exp_q.pop_front();
        rd = e.rdata;
        mem_txn(k, rd, o);
        vectors++;
        if (!o.ok || o.wait_cyc != (k == 0 ? 1 : 2))
          begin miscompares++; $display("FAIL arb_latency r%0d k%0d: got %0d cycles expected %0d", r, k, o.wait_cyc, (k == 0 ? 1 : 2)); end
        vectors++;
        if ({o.we, o.addr} !== {e.we, e.addr})
          begin miscompares++; $display("FAIL arb_grant r%0d k%0d: got we %b addr %h expected we %b addr %h", r, k, o.we, o.addr, e.we, e.addr); end
        vectors++;
        if ({o.stable, o.early_rdy, o.ic_rdy, o.dc_rdy, o.req_after} !== {1'b1, 1'b0, !e.is_dc, e.is_dc, 1'b0})
          begin miscompares++; $display("FAIL arb_ready r%0d k%0d: got %b expected %b", r, k,
            {o.stable, o.early_rdy, o.ic_rdy, o.dc_rdy, o.req_after}, {1'b1, 1'b0, !e.is_dc, e.is_dc, 1'b0}); end
        mdl_line = rd;
        vectors++;
        if (o.line !== mdl_line) begin miscompares++; $display("FAIL arb_line r%0d k%0d: got %h expected %h", r, k, o.line, mdl_line); end
        mdl_last_dc = e.is_dc;
        if (e.is_dc) dc_rd_i = 1'b0; else ic_rd_i = 1'b0;
      end
    end
  endtask

  task automatic test_single_read();
    exp_t e; obs_t o; logic [LW-1:0] rd;
    @(negedge clk_i);
    rd = rnd_line();
    exp_q.push_back('{is_dc: 1'b0, we: 1'b0, addr: 32'h100, wdata: '0, rdata: rd});
    ic_addr_i = 32'h104; ic_rd_i = 1'b1;
    mem_txn(2, rd, o);
    e = exp_q.pop_front();
    vectors++;
    if (!o.ok || o.wait_cyc != 1) begin miscompares++; $display("FAIL single_latency: got %0d cycles expected 1", o.wait_cyc); end
    vectors++;
    if ({o.we, o.addr} !== {e.we, e.addr})
      begin miscompares++; $display("FAIL single_req: got we %b addr %h expected we %b addr %h", o.we, o.addr, e.we, e.addr); end
    vectors++;
    if ({o.stable, o.early_rdy, o.ic_rdy, o.dc_rdy, o.req_after} !== 5'b10100)
      begin miscompares++; $display("FAIL single_ready: got %b expected 10100", {o.stable, o.early_rdy, o.ic_rdy, o.dc_rdy, o.req_after}); end
    mdl_line = e.rdata;
    vectors++;
    if (o.line !== mdl_line) begin miscompares++; $display("FAIL single_line: got %h expected %h", o.line, mdl_line); end
    mdl_last_dc = 1'b0;
    ic_rd_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if ({ic_ready_o, dc_ready_o, mem_req_o} !== 3'b000)
      begin miscompares++; $display("FAIL single_pulse: got %b expected 000", {ic_ready_o, dc_ready_o, mem_req_o}); end
  endtask

  task automatic test_write_then_read();
    exp_t e; obs_t o;
    @(negedge clk_i);
    exp_q.push_back('{is_dc: 1'b1, we: 1'b1, addr: 32'h4000, wdata: {16{8'hA5}}, rdata: rnd_line()});
    exp_q.push_back('{is_dc: 1'b1, we: 1'b0, addr: 32'h4000, wdata: '0, rdata: rnd_line()});
    dc_addr_i = 32'h4004; dc_line_i = {16{8'hA5}}; dc_wr_i = 1'b1; dc_rd_i = 1'b1;
    e = exp_q.pop_front();
    mem_txn(1, e.rdata, o);
    vectors++;
    if ({o.ok, o.we, o.addr} !== {1'b1, e.we, e.addr})
      begin miscompares++; $display("FAIL wr_req: got ok %b we %b addr %h expected ok 1 we %b addr %h", o.ok, o.we, o.addr, e.we, e.addr); end
    vectors++;
    if (o.wdata !== e.wdata) begin miscompares++; $display("FAIL wr_data: got %h expected %h", o.wdata, e.wdata); end
    vectors++;
    if ({o.stable, o.early_rdy, o.ic_rdy, o.dc_rdy} !== 4'b1001)
      begin miscompares++; $display("FAIL wr_ready: got %b expected 1001", {o.stable, o.early_rdy, o.ic_rdy, o.dc_rdy}); end
    vectors++;
    if (o.line !== mdl_line) begin miscompares++; $display("FAIL wr_line_kept: got %h expected %h", o.line, mdl_line); end
    mdl_last_dc = 1'b1;
    dc_wr_i = 1'b0; dc_line_i = rnd_line();
    e = exp_q.pop_front();
    mem_txn(0, e.rdata, o);
    vectors++;
    if ({o.ok, o.wait_cyc, o.we, o.addr} !== {1'b1, 32'd2, e.we, e.addr})
      begin miscompares++; $display("FAIL rd_after_wr: got wait %0d we %b addr %h expected wait 2 we %b addr %h", o.wait_cyc, o.we, o.addr, e.we, e.addr); end
    mdl_line = e.rdata;
    vectors++;
    if ({o.ic_rdy, o.dc_rdy} !== 2'b01 || o.line !== mdl_line)
      begin miscompares++; $display("FAIL rd_after_wr_resp: got rdy %b line %h expected rdy 01 line %h", {o.ic_rdy, o.dc_rdy}, o.line, mdl_line); end
    dc_rd_i = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e; obs_t o; int cnt; bit rdy;
    @(negedge clk_i);
    ic_addr_i = 32'h501C; ic_rd_i = 1'b1;
    cnt = 0;
    while (mem_req_o !== 1'b1 && cnt < 10) begin @(negedge clk_i); cnt++; end
    vectors++;
    if (mem_req_o !== 1'b1 || timeout_o !== 1'b0)
      begin miscompares++; $display("FAIL to_start: got req %b timeout %b expected req 1 timeout 0", mem_req_o, timeout_o); end
    cnt = 0; rdy = 0;
    while (mem_req_o === 1'b1 && cnt < int'(TO) + 4) begin
      if (ic_ready_o !== 1'b0 || dc_ready_o !== 1'b0) rdy = 1;
      @(negedge clk_i);
      cnt++;
    end
    vectors++;
    if (cnt != int'(TO)) begin miscompares++; $display("FAIL to_req_cycles: got %0d expected %0d", cnt, TO); end
    vectors++;
    if ({timeout_o, rdy, ic_ready_o, dc_ready_o} !== 4'b1000)
      begin miscompares++; $display("FAIL to_flag: got %b expected 1000", {timeout_o, rdy, ic_ready_o, dc_ready_o}); end
    exp_q.push_back('{is_dc: 1'b0, we: 1'b0, addr: 32'h5010, wdata: '0, rdata: rnd_line()});
    e = exp_q.pop_front();
    mem_txn(3, e.rdata, o);
    vectors++;
    if ({o.ok, o.wait_cyc, o.addr} !== {1'b1, 32'd1, e.addr})
      begin miscompares++; $display("FAIL to_reissue: got ok %b wait %0d addr %h expected ok 1 wait 1 addr %h", o.ok, o.wait_cyc, o.addr, e.addr); end
    mdl_line = e.rdata;
    vectors++;
    if ({o.ic_rdy, o.dc_rdy, timeout_o} !== 3'b101 || o.line !== mdl_line)
      begin miscompares++; $display("FAIL to_complete: got rdy/to %b line %h expected 101 line %h", {o.ic_rdy, o.dc_rdy, timeout_o}, o.line, mdl_line); end
    mdl_last_dc = 1'b0;
    ic_rd_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o; int cnt;
    @(negedge clk_i);
    dc_addr_i = 32'h6000; dc_rd_i = 1'b1;
    cnt = 0;
    while (mem_req_o !== 1'b1 && cnt < 10) begin @(negedge clk_i); cnt++; end
    vectors++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h6000})
      begin miscompares++; $display("FAIL rm_busy_dc: got req %b addr %h expected req 1 addr 00006000", mem_req_o, mem_addr_o); end
    ic_addr_i = 32'h7000; ic_rd_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if ({mem_req_o, mem_we_o, ic_ready_o, dc_ready_o, timeout_o} !== 5'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0 || line_o !== '0)
      begin miscompares++; $display("FAIL rm_async: got ctl %b addr %h line %h expected all 0",
        {mem_req_o, mem_we_o, ic_ready_o, dc_ready_o, timeout_o}, mem_addr_o, line_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    mdl_last_dc = 1'b1;
    mdl_line    = '0;
    exp_q.push_back('{is_dc: 1'b0, we: 1'b0, addr: 32'h7000, wdata: '0, rdata: rnd_line()});
    exp_q.push_back('{is_dc: 1'b1, we: 1'b0, addr: 32'h6000, wdata: '0, rdata: rnd_line()});
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      mem_txn(1, e.rdata, o);
      mdl_line = e.rdata;
      vectors++;
      if ({o.ok, o.addr, o.ic_rdy, o.dc_rdy} !== {1'b1, e.addr, !e.is_dc, e.is_dc} || o.line !== mdl_line)
        begin miscompares++; $display("FAIL rm_order k%0d: got addr %h rdy %b line %h expected addr %h rdy %b line %h",
          k, o.addr, {o.ic_rdy, o.dc_rdy}, o.line, e.addr, {!e.is_dc, e.is_dc}, mdl_line); end
      mdl_last_dc = e.is_dc;
      if (e.is_dc) dc_rd_i = 1'b0; else ic_rd_i = 1'b0;
    end
  endtask

  task automatic test_idle_ack();
    repeat (2) @(negedge clk_i);
    mem_ack_i = 1'b1; mem_rdata_i = rnd_line();
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({mem_req_o, ic_ready_o, dc_ready_o} !== 3'b000 || line_o !== mdl_line)
        begin miscompares++; $display("FAIL idle_ack c%0d: got ctl %b line %h expected 000 line %h",
          i, {mem_req_o, ic_ready_o, dc_ready_o}, line_o, mdl_line); end
      @(negedge clk_i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arbitration();
    test_single_read();
    test_write_then_read();
    test_timeout();
    test_reset_mid();
    test_idle_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
